// File: rtl/kvs_responder.sv
// kvs_responder: direct-mapped XOR-hashed key table with GET/SET/DEL and fixed 3-cycle response latency.
// Define KVS_COLLISION_EN to refuse a SET that would evict a different valid key (default build evicts).
`timescale 1ns/1ps
module kvs_responder #(
  parameter int KEY_SIZE  = 96,
  parameter int HASH_BITS = 10
) (
  input  logic                clk156,
  input  logic                eth_rst,
  input  logic [KEY_SIZE-1:0] in_key,
  input  logic [3:0]          in_flag,
  input  logic                in_valid,
  output logic                out_valid,
  output logic [3:0]          out_flag,
  output logic                init_done,
  output logic [7:0]          debug
);
  localparam int DEPTH = 1 << HASH_BITS;
  localparam int NS = (KEY_SIZE + HASH_BITS - 1) / HASH_BITS;
  localparam logic [1:0] CLEAR = 2'd0, RUN = 2'd1;
  localparam logic [3:0] OP_GET = 4'b0001, OP_SET = 4'b0010, OP_DEL = 4'b0100;
`ifdef KVS_COLLISION_EN
  localparam logic EVICT = 1'b0;
`else
  localparam logic EVICT = 1'b1;
`endif
  function automatic logic [HASH_BITS-1:0] hash(input logic [KEY_SIZE-1:0] k);
    logic [NS*HASH_BITS-1:0] p;
    logic [HASH_BITS-1:0] h;
    p = '0;
    p[KEY_SIZE-1:0] = k;
    h = '0;
    for (int i = 0; i < NS; i++) h ^= p[i*HASH_BITS +: HASH_BITS];
    return h;
  endfunction
  logic [1:0]          state_q, state_d;
  logic [HASH_BITS-1:0] clr_addr_q;
  logic                clr_we;
  logic                s0_v_q, s1_v_q, s2_v_q, s0_err_q, s1_err_q, s2_err_q;
  logic [3:0]          s0_op_q, s1_op_q, s2_op_q;
  logic [KEY_SIZE-1:0] s0_key_q, s1_key_q, s2_key_q;
  logic [HASH_BITS-1:0] s1_idx_q, s2_idx_q, wr_idx_q;
  logic [KEY_SIZE:0]   mem [DEPTH];
  logic [KEY_SIZE:0]   rd_q, wr_ent_q, ent, s3_wd;
  logic                wr_v_q, hit, set_wr, s3_we, out_valid_q;
  logic [3:0]          out_flag_q, out_flag_d;
  always_ff @(posedge clk156) begin
    if (eth_rst) state_q <= CLEAR;
    else state_q <= state_d;
  end
  always_comb state_d = (state_q == CLEAR && clr_addr_q == '1) ? RUN : state_q;
  always_comb begin
    init_done = state_q == RUN;
    clr_we = state_q == CLEAR;
  end
  always_ff @(posedge clk156) begin
    if (eth_rst) clr_addr_q <= '0;
    else if (clr_we) clr_addr_q <= clr_addr_q + HASH_BITS'(1);
  end
  always_ff @(posedge clk156) begin
    s0_v_q <= !eth_rst && in_valid;
    s1_v_q <= !eth_rst && s0_v_q;
    s2_v_q <= !eth_rst && s1_v_q;
    out_valid_q <= !eth_rst && s2_v_q;
    wr_v_q <= !eth_rst && s3_we;
    out_flag_q <= eth_rst ? 4'b0000 : s2_v_q ? out_flag_d : out_flag_q;
    s0_key_q <= in_key;
    s0_op_q <= in_flag;
    s0_err_q <= clr_we;
    s1_key_q <= s0_key_q;
    s1_op_q <= s0_op_q;
    s1_err_q <= s0_err_q;
    s1_idx_q <= hash(s0_key_q);
    s2_key_q <= s1_key_q;
    s2_op_q <= s1_op_q;
    s2_err_q <= s1_err_q;
    s2_idx_q <= s1_idx_q;
    wr_idx_q <= s2_idx_q;
    wr_ent_q <= s3_wd;
  end
  // Read-during-write returns old data, so only the previous edge's write ever needs forwarding.
  always_ff @(posedge clk156) begin
    if (clr_we || s3_we) mem[clr_we ? clr_addr_q : s2_idx_q] <= clr_we ? '0 : s3_wd;
    rd_q <= mem[s1_idx_q];
  end
  assign ent = (wr_v_q && wr_idx_q == s2_idx_q) ? wr_ent_q : rd_q;
  assign hit = ent[KEY_SIZE] && ent[KEY_SIZE-1:0] == s2_key_q;
  assign set_wr = s2_op_q == OP_SET && !hit && (!ent[KEY_SIZE] || EVICT);
  assign s3_we = s2_v_q && !s2_err_q && !eth_rst && (set_wr || (s2_op_q == OP_DEL && hit));
  assign s3_wd = {set_wr, s2_key_q};
  always_comb out_flag_d = s2_err_q ? 4'b1000 :
                           s2_op_q == OP_GET ? {3'b000, hit} :
                           s2_op_q == OP_SET ? (hit ? 4'b0011 : set_wr ? 4'b0010 : 4'b1000) :
                           (s2_op_q == OP_DEL && hit) ? 4'b0101 : 4'b0000;
  assign out_valid = out_valid_q;
  assign out_flag = out_flag_q;
  assign debug = {3'b000, init_done, state_q, out_flag_q[1:0]};
endmodule

// File: tb/tb_kvs_responder.sv
// tb_kvs_responder: random and directed requests checked cycle-by-cycle against a table model.
`timescale 1ns/1ps
module tb_kvs_responder;
  localparam logic [3:0] GET = 4'b0001, SET = 4'b0010, DEL = 4'b0100, NOP = 4'b0000;
  localparam logic [95:0] K = 96'h0123_4567_89AB_CDEF_0011_2233;
  typedef struct {int due; logic [3:0] f;} exp_t;
  logic clk = 0, eth_rst = 1, in_valid = 0, out_valid, init_done;
  logic [95:0] in_key = '0;
  logic [3:0] in_flag = '0, out_flag, last_f = '0;
  logic [7:0] debug;
  int pcnt = 0, nrst = 0, n_chk = 0, n_fail = 0, npulse = 0, p0;
  logic rst_q = 1;
  logic mv [1024];
  logic [95:0] mk [1024];
  logic [95:0] pool [8];
  exp_t q[$];
  kvs_responder dut (.clk156(clk), .eth_rst(eth_rst), .in_key(in_key), .in_flag(in_flag),
    .in_valid(in_valid), .out_valid(out_valid), .out_flag(out_flag), .init_done(init_done), .debug(debug));
  always #3 clk = ~clk;
  always @(posedge clk) begin
    pcnt <= pcnt + 1;
    nrst <= eth_rst ? 0 : nrst + 1;
    rst_q <= eth_rst;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, pcnt);
    end
  endtask
  function automatic logic [3:0] model(input logic [95:0] k, input logic [3:0] op, input logic run);
    logic [9:0] h = '0;
    logic hit;
    for (int i = 0; i < 96; i++) h[i % 10] ^= k[i];
    if (!run) return 4'b1000;
    hit = mv[h] && mk[h] == k;
    if (op == GET) return {3'b000, hit};
    if (op == SET) begin
      if (hit) return 4'b0011;
`ifdef KVS_COLLISION_EN
      if (mv[h]) return 4'b1000;
`endif
      mv[h] = 1;
      mk[h] = k;
      return 4'b0010;
    end
    if (op == DEL && hit) begin
      mv[h] = 0;
      return 4'b0101;
    end
    return 4'b0000;
  endfunction
  task automatic req(input logic [3:0] op, input logic [95:0] k);
    exp_t e;
    @(posedge clk); #1;
    in_valid = 1;
    in_flag = op;
    in_key = k;
    e.due = pcnt + 4;
    e.f = model(k, op, nrst >= 1024);
    q.push_back(e);
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 0;
    end
  endtask
  task automatic reset(input int n);
    @(posedge clk); #1;
    eth_rst = 1;
    in_valid = 0;
    foreach (mv[i]) mv[i] = 0;
    repeat (n) @(posedge clk);
    #1 eth_rst = 0;
  endtask
  initial forever begin
    @(negedge clk);
    if (rst_q) begin
      q.delete();
      last_f = '0;
    end
    if (out_valid) npulse++;
    if (q.size() > 0 && q[0].due == pcnt) begin
      check("resp_valid", {31'b0, out_valid}, 1);
      check("resp_flag", {28'b0, out_flag}, {28'b0, q[0].f});
      last_f = q[0].f;
      void'(q.pop_front());
    end else begin
      check("idle_valid", {31'b0, out_valid}, 0);
      check("held_flag", {28'b0, out_flag}, {28'b0, last_f});
    end
    check("init_done", {31'b0, init_done}, {31'b0, nrst >= 1024});
    check("debug", {26'b0, debug[7:4], debug[1:0]}, {26'b0, 3'b000, nrst >= 1024, last_f[1:0]});
  end
  initial begin
    foreach (mv[i]) mv[i] = 0;
    repeat (4) @(posedge clk);
    #1 eth_rst = 0;
    idle(9);
    req(GET, K);
    idle(1);
    while (nrst < 1023) idle(1);
    req(SET, K);
    req(GET, K);
    idle(4);
    foreach (pool[i]) if (i < 5) begin
      req(i == 0 ? SET : i == 1 ? GET : i == 2 ? SET : i == 3 ? DEL : GET, K);
      idle(3);
    end
    req(SET, K); req(GET, K); req(DEL, K); req(GET, K);
    idle(4);
    req(SET, K); req(NOP, K); req(GET, K); req(DEL, K); idle(1); req(GET, K);
    idle(4);
    req(SET, K); req(SET, K ^ 96'h401); req(GET, K); req(GET, K ^ 96'h401);
    idle(4);
    req(SET, K ^ 96'h802);
    idle(4);
    req(GET, K); req(GET, K); req(GET, K);
    reset(4);
    while (nrst < 1024) idle(1);
    req(GET, K);
    req(GET, K ^ 96'h401);
    idle(6);
    for (int i = 0; i < 4; i++) begin
      pool[i] = {$urandom, $urandom, $urandom};
      pool[i + 4] = pool[i] ^ 96'h401;
    end
    p0 = npulse;
    for (int i = 0; i < 1000; i++) begin
      int r;
      r = $urandom_range(0, 7);
      req(r < 2 ? GET : r < 4 ? SET : r < 6 ? DEL : r == 6 ? NOP : 4'($urandom), pool[$urandom_range(0, 7)]);
    end
    idle(8);
    check("pulse_count", npulse - p0, 1000);
    check("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
